branch_predictor: RTL and testbench

Fetch-stage direct-mapped branch target buffer with 2-bit saturating direction counters. Every cycle it looks up the current fetch PC and, on a confident hit, gives PC_control the predicted taken target for the next fetch. Branches resolved in EM are written back to train the counters and targets, and the block flags mispredictions so the pipeline can flush.

---
 rtl/bp_pkg.sv | 25 ++
 rtl/bp_sat_counter.sv | 20 ++
 rtl/branch_predictor.sv | 145 ++++++++++++++
 tb/tb_branch_predictor.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared definitions for the fetch-stage branch predictor: direction counter
// encoding, reset counter default and the BTB entry layout.
package bp_pkg;

    // 2-bit saturating direction counter encoding
    localparam logic [1:0] CNT_SNT = 2'b00;  // strong not-taken
    localparam logic [1:0] CNT_WNT = 2'b01;  // weak not-taken
    localparam logic [1:0] CNT_WT  = 2'b10;  // weak taken
    localparam logic [1:0] CNT_ST  = 2'b11;  // strong taken

    // Counter value loaded into every entry at reset
    localparam logic [1:0] RESET_CNT_DEFAULT = CNT_WNT;

    // Widest tag needed: smallest table (4 entries, 2 index bits) leaves PC[31:4]
    localparam int unsigned BP_TAG_MAX_W = 28;

    // One BTB entry; tags narrower than BP_TAG_MAX_W are stored zero-extended
    typedef struct packed {
        logic                    valid;
        logic [BP_TAG_MAX_W-1:0] tag;
        logic [29:0]             target;
        logic [1:0]              cnt;
    } btb_entry_t;

endpackage

// File: rtl/bp_sat_counter.sv
// Next-state function of a 2-bit saturating direction counter.
module bp_sat_counter
    import bp_pkg::*;
(
    input  logic [1:0] cnt,
    input  logic       taken,
    output logic [1:0] cnt_next
);

    // Step toward strong-taken on taken, toward strong-not-taken otherwise
    always_comb begin
        cnt_next = cnt;
        if (taken) begin
            if (cnt != CNT_ST) cnt_next = cnt + 2'd1;
        end else begin
            if (cnt != CNT_SNT) cnt_next = cnt - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters for the fetch stage.
// Lookup is combinational from PC; EM-stage resolutions train the table.
// Optional resolved-branch / mispredict statistics: define BP_STATS_EN.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int unsigned ENTRIES   = 16,
    parameter logic [1:0]  RESET_CNT = RESET_CNT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC,
    output logic        branch_taken,
    output logic [31:0] PC_Predict,
    input  logic        EM_BrValid,
    input  logic [31:0] EM_PC,
    input  logic        EM_Taken,
    input  logic [31:0] EM_PCBranch,
    input  logic        EM_PredTaken,
    input  logic [31:0] EM_PredTarget,
    output logic        EM_Mispredict
`ifdef BP_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
`endif
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = 30 - IDX_W;

    btb_entry_t table_q [ENTRIES];
    btb_entry_t table_d [ENTRIES];

    logic [IDX_W-1:0]        rd_idx;
    logic [BP_TAG_MAX_W-1:0] rd_tag;
    logic                    rd_valid;
    logic                    rd_tag_match;
    logic                    rd_cnt_msb;
    logic [29:0]             rd_target;

    logic [IDX_W-1:0]        wr_idx;
    logic [BP_TAG_MAX_W-1:0] wr_tag;
    logic                    wr_hit;
    logic [1:0]              wr_cnt;
    logic [1:0]              wr_cnt_next;

    // Word-offset bits never participate in indexing or tagging
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{PC[1:0], EM_PC[1:0], EM_PCBranch[1:0]};

    // Fetch-side lookup: reads the registered table, so same-cycle updates are not seen
    always_comb begin
        rd_idx              = PC[IDX_W+1:2];
        rd_tag              = '0;
        rd_tag[TAG_W-1:0]   = PC[31:IDX_W+2];
        rd_valid            = table_q[rd_idx].valid;
        rd_tag_match        = (table_q[rd_idx].tag == rd_tag);
        rd_cnt_msb          = table_q[rd_idx].cnt[1];
        rd_target           = table_q[rd_idx].target;
        branch_taken        = rd_valid && rd_tag_match && rd_cnt_msb;
        PC_Predict          = branch_taken ? {rd_target, 2'b00} : (PC + 32'd4);
    end

    // Mispredict: wrong direction, or taken-as-predicted but to the wrong target
    always_comb begin
        EM_Mispredict = EM_BrValid &&
                        ((EM_PredTaken != EM_Taken) ||
                         (EM_Taken && EM_PredTaken && (EM_PredTarget != EM_PCBranch)));
    end

    // EM-side decode of the entry being trained
    always_comb begin
        wr_idx            = EM_PC[IDX_W+1:2];
        wr_tag            = '0;
        wr_tag[TAG_W-1:0] = EM_PC[31:IDX_W+2];
        wr_hit            = table_q[wr_idx].valid && (table_q[wr_idx].tag == wr_tag);
        wr_cnt            = table_q[wr_idx].cnt;
    end

    bp_sat_counter u_sat_counter (
        .cnt      (wr_cnt),
        .taken    (EM_Taken),
        .cnt_next (wr_cnt_next)
    );

    // Training: hits adjust counter/target, taken misses allocate, not-taken misses are dropped
    always_comb begin
        table_d = table_q;
        if (EM_BrValid) begin
            if (wr_hit) begin
                table_d[wr_idx].cnt = wr_cnt_next;
                if (EM_Taken) table_d[wr_idx].target = EM_PCBranch[31:2];
            end else if (EM_Taken) begin
                table_d[wr_idx] = '{valid: 1'b1, tag: wr_tag,
                                    target: EM_PCBranch[31:2], cnt: CNT_WT};
            end
        end
    end

    // Table storage with asynchronous clear of every entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                table_q[i] <= '{valid: 1'b0, tag: '0, target: '0, cnt: RESET_CNT};
            end
        end else begin
            table_q <= table_d;
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] stat_branches_q;
    logic [31:0] stat_branches_d;
    logic [31:0] stat_mispredicts_q;
    logic [31:0] stat_mispredicts_d;

    // Saturating event counters
    always_comb begin
        stat_branches_d    = stat_branches_q;
        stat_mispredicts_d = stat_mispredicts_q;
        if (EM_BrValid && (stat_branches_q != '1)) begin
            stat_branches_d = stat_branches_q + 32'd1;
        end
        if (EM_Mispredict && (stat_mispredicts_q != '1)) begin
            stat_mispredicts_d = stat_mispredicts_q + 32'd1;
        end
    end

    // Statistics registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_branches_q    <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            stat_branches_q    <= stat_branches_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

    assign stat_branches    = stat_branches_q;
    assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor (ENTRIES=16) against a behavioural
// model that keys each slot by the full branch address that owns it.
module tb_branch_predictor;

    localparam int unsigned N = 16;

    logic        clk;
    logic        rst;
    logic [31:0] PC;
    logic        branch_taken;
    logic [31:0] PC_Predict;
    logic        EM_BrValid;
    logic [31:0] EM_PC;
    logic        EM_Taken;
    logic [31:0] EM_PCBranch;
    logic        EM_PredTaken;
    logic [31:0] EM_PredTarget;
    logic        EM_Mispredict;
`ifdef BP_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit          m_valid [N];
    logic [31:0] m_owner [N];
    logic [31:0] m_tgt   [N];
    int          m_cnt   [N];
    int unsigned m_br;
    int unsigned m_mp;

    branch_predictor #(.ENTRIES(16), .RESET_CNT(2'b01)) dut (
        .clk           (clk),
        .rst           (rst),
        .PC            (PC),
        .branch_taken  (branch_taken),
        .PC_Predict    (PC_Predict),
        .EM_BrValid    (EM_BrValid),
        .EM_PC         (EM_PC),
        .EM_Taken      (EM_Taken),
        .EM_PCBranch   (EM_PCBranch),
        .EM_PredTaken  (EM_PredTaken),
        .EM_PredTarget (EM_PredTarget),
        .EM_Mispredict (EM_Mispredict)
`ifdef BP_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int slot(input logic [31:0] pc);
        return int'((pc >> 2) % N);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        int s = slot(pc);
        return m_valid[s] && ((m_owner[s] >> 2) == (pc >> 2));
    endfunction

    function automatic bit m_pred_t(input logic [31:0] pc);
        return m_hit(pc) && (m_cnt[slot(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_pred_pc(input logic [31:0] pc);
        return m_pred_t(pc) ? m_tgt[slot(pc)] : pc + 32'd4;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 1'b0;
            m_cnt[i]   = 1;
            m_owner[i] = '0;
            m_tgt[i]   = '0;
        end
        m_br = 0;
        m_mp = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive, check combinational outputs mid-cycle, then advance model at the edge
    task automatic cycle(input logic [31:0] pc, input bit br, input logic [31:0] epc,
                         input bit tk, input logic [31:0] tgt, input bit pt,
                         input logic [31:0] ptgt);
        bit exp_mp;
        int s;
        PC            = pc;
        EM_BrValid    = br;
        EM_PC         = epc;
        EM_Taken      = tk;
        EM_PCBranch   = tgt;
        EM_PredTaken  = pt;
        EM_PredTarget = ptgt;
        exp_mp = br && ((pt != tk) || (tk && pt && (ptgt != tgt)));
        @(negedge clk);
        chk("branch_taken", {31'd0, branch_taken}, {31'd0, m_pred_t(pc)});
        chk("PC_Predict", PC_Predict, m_pred_pc(pc));
        chk("EM_Mispredict", {31'd0, EM_Mispredict}, {31'd0, exp_mp});
`ifdef BP_STATS_EN
        chk("stat_branches", stat_branches, m_br);
        chk("stat_mispredicts", stat_mispredicts, m_mp);
`endif
        @(posedge clk);
        if (br) begin
            s = slot(epc);
            if (m_hit(epc)) begin
                if (tk) m_cnt[s] = (m_cnt[s] < 3) ? m_cnt[s] + 1 : 3;
                else    m_cnt[s] = (m_cnt[s] > 0) ? m_cnt[s] - 1 : 0;
                if (tk) m_tgt[s] = tgt & ~32'h3;
            end else if (tk) begin
                m_valid[s] = 1'b1;
                m_owner[s] = epc;
                m_tgt[s]   = tgt & ~32'h3;
                m_cnt[s]   = 2;
            end
            m_br++;
            if (exp_mp) m_mp++;
        end
        #1;
    endtask

    task automatic look(input logic [31:0] pc);
        cycle(pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    // Resolve a branch carrying the prediction fetch would have made for it
    task automatic train(input logic [31:0] pc, input bit tk, input logic [31:0] tgt);
        cycle(pc, 1'b1, pc, tk, tgt, m_pred_t(pc), m_pred_pc(pc));
    endtask

    function automatic logic [31:0] rnd_pc();
        return 32'h1000 | ($urandom_range(0, 2) << 6) | ($urandom_range(0, 3) << 2);
    endfunction

    initial begin
        rst = 1'b1;
        PC = 32'h40;
        EM_BrValid = 1'b0;
        EM_PC = '0;
        EM_Taken = 1'b0;
        EM_PCBranch = '0;
        EM_PredTaken = 1'b0;
        EM_PredTarget = '0;
        m_reset();
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;

        // Reset state
        look(32'h40);
        chk("reset_pred", PC_Predict, 32'h44);

        // Allocation on a taken miss
        cycle(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
        look(32'h40);
        chk("alloc_pred", PC_Predict, 32'h100);

        // Counter saturation and decay
        train(32'h40, 1'b1, 32'h100);
        train(32'h40, 1'b1, 32'h100);
        train(32'h40, 1'b1, 32'h100);
        train(32'h40, 1'b0, 32'h0);
        look(32'h40);
        chk("after_one_nt", {31'd0, branch_taken}, 32'd1);
        train(32'h40, 1'b0, 32'h0);
        look(32'h40);
        chk("after_two_nt", {31'd0, branch_taken}, 32'd0);

        // Index alias with a different tag evicts the old entry
        train(32'h40, 1'b1, 32'h100);
        train(32'h440, 1'b1, 32'h300);
        look(32'h40);
        chk("evicted", {31'd0, branch_taken}, 32'd0);
        look(32'h440);
        chk("alias_pred", PC_Predict, 32'h300);

        // Target mispredict on a correctly predicted direction
        train(32'h40, 1'b1, 32'h100);
        cycle(32'h40, 1'b1, 32'h40, 1'b1, 32'h200, 1'b1, 32'h100);
        look(32'h40);
        chk("retarget", PC_Predict, 32'h200);

        // Back-to-back updates to one index
        train(32'h80, 1'b1, 32'h180);
        train(32'h80, 1'b0, 32'h0);
        train(32'h80, 1'b0, 32'h0);
        look(32'h80);

        // PC+4 wraps
        look(32'hFFFF_FFFC);
        chk("wrap", PC_Predict, 32'h0);

        // Asynchronous reset while an update is presented
        PC            = 32'h40;
        EM_BrValid    = 1'b1;
        EM_PC         = 32'h80;
        EM_Taken      = 1'b1;
        EM_PCBranch   = 32'h500;
        EM_PredTaken  = 1'b0;
        EM_PredTarget = 32'h84;
        #2 rst = 1'b1;
        #1;
        chk("rst_bt", {31'd0, branch_taken}, 32'd0);
        chk("rst_pred", PC_Predict, 32'h44);
        chk("rst_mp", {31'd0, EM_Mispredict}, 32'd1);
`ifdef BP_STATS_EN
        chk("rst_stat_br", stat_branches, 32'd0);
`endif
        @(posedge clk);
        #2;
        EM_BrValid = 1'b0;
        rst = 1'b0;
        m_reset();
        @(posedge clk);
        #1;
        look(32'h80);
        look(32'h40);
        chk("post_rst_40", {31'd0, branch_taken}, 32'd0);

        // Five branches, two of them mispredicted
        train(32'h40, 1'b1, 32'h100);
        train(32'h40, 1'b1, 32'h100);
        train(32'h80, 1'b0, 32'h0);
        train(32'h80, 1'b0, 32'h0);
        train(32'h40, 1'b0, 32'h0);
        look(32'h0);
`ifdef BP_STATS_EN
        chk("stat_br5", stat_branches, 32'd5);
        chk("stat_mp2", stat_mispredicts, 32'd2);
`endif

        // Randomized traffic over a few colliding addresses
        for (int i = 0; i < 300; i++) begin
            logic [31:0] fpc;
            logic [31:0] epc;
            logic [31:0] tgt;
            bit          br;
            bit          tk;
            bit          pt;
            logic [31:0] ptgt;
            fpc = rnd_pc();
            epc = rnd_pc();
            tgt = 32'h2000 + ($urandom_range(0, 7) << 2);
            br  = ($urandom_range(0, 4) < 3);
            tk  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) != 0) begin
                pt   = m_pred_t(epc);
                ptgt = m_pred_pc(epc);
            end else begin
                pt   = $urandom_range(0, 1) == 1;
                ptgt = 32'h2000 + ($urandom_range(0, 7) << 2);
            end
            cycle(fpc, br, epc, tk, tgt, pt, ptgt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
